// File: rtl/key_conditioner.sv
// Button front end for the metronome: synchronizes and debounces five raw buttons,
// turns tempo up/down presses into single pulses with auto-repeat, and latches the meter selection.
module key_conditioner #(
    parameter int DB_LEN     = 2,
    parameter int REP_DELAY  = 12,
    parameter int REP_PERIOD = 3
) (
    input  logic       dclk22,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_m2,
    input  logic       btn_m3,
    input  logic       btn_m4,
    output logic       up,
    output logic       down,
    output logic [2:0] meter,
    output logic       repeating
);

    localparam int NB = 5;
    localparam logic [3:0] DB_LAST     = 4'(DB_LEN - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(REP_DELAY - 1);
    localparam logic [7:0] PERIOD_LAST = 8'(REP_PERIOD);

    typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} chan_state_t;

    // Bit order everywhere: 0 up, 1 down, 2 m2, 3 m3, 4 m4.
    logic [NB-1:0] raw;
    logic [NB-1:0] s1;
    logic [NB-1:0] s2;
    logic [NB-1:0] db;
    logic [1:0]    pulse;
    logic [1:0]    rep;
    logic [2:0]    mdb_q;
    logic [2:0]    mrise;
    logic          conflict;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign raw = {btn_m4, btn_m3, btn_m2, btn_down, btn_up};

    always_ff @(posedge dclk22) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    generate
        for (genvar i = 0; i < NB; i++) begin : g_db
            logic       lvl;
            logic [3:0] cnt;

            always_ff @(posedge dclk22) begin
                if (rst) begin
                    lvl <= 1'b0;
                    cnt <= '0;
                end else if (s2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    lvl <= s2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end

            assign db[i] = lvl;
        end
    endgenerate

    assign conflict = db[0] & db[1];

    // One FSM per tempo channel. The lock keeps a channel quiet after an up/down
    // conflict until its own button has been seen released.
    generate
        for (genvar c = 0; c < 2; c++) begin : g_ch
            chan_state_t st;
            logic [7:0]  cnt;
            logic        lock;
            logic        pls;

            always_ff @(posedge dclk22) begin
                if (rst) begin
                    st   <= IDLE;
                    cnt  <= '0;
                    lock <= 1'b0;
                    pls  <= 1'b0;
                end else if (conflict) begin
                    st   <= IDLE;
                    cnt  <= '0;
                    lock <= 1'b1;
                    pls  <= 1'b0;
                end else if (!db[c]) begin
                    st   <= IDLE;
                    cnt  <= '0;
                    lock <= 1'b0;
                    pls  <= 1'b0;
                end else begin
                    pls <= 1'b0;
                    case (st)
                        IDLE: begin
                            if (!lock) begin
                                st  <= FIRST;
                                pls <= 1'b1;
                            end
                        end
                        FIRST: begin
                            st  <= HOLD;
                            cnt <= 8'd1;
                        end
                        HOLD: begin
                            if (cnt == HOLD_LAST) begin
                                st  <= REPEAT;
                                cnt <= 8'd1;
                                pls <= 1'b1;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
                        end
                        REPEAT: begin
                            if (cnt == PERIOD_LAST) begin
                                cnt <= 8'd1;
                                pls <= 1'b1;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
                        end
                        default: st <= IDLE;
                    endcase
                end
            end

            assign pulse[c] = pls;
            assign rep[c]   = (st == REPEAT);
        end
    endgenerate

    assign up        = pulse[0];
    assign down      = pulse[1];
    assign repeating = |rep;

    assign mrise = db[4:2] & ~mdb_q;

    always_ff @(posedge dclk22) begin
        if (rst) begin
            meter <= 3'b001;
            mdb_q <= '0;
        end else begin
            mdb_q <= db[4:2];
            if (mrise[2])      meter <= 3'b001;
            else if (mrise[1]) meter <= 3'b010;
            else if (mrise[0]) meter <= 3'b100;
        end
    end

endmodule
